// File: rtl/alu_operand_loader_if.sv
// Operand-loader bus: the switch/button inputs and the operand/status outputs.
// The slave modport belongs to the loader; the master modport belongs to whatever drives the switches.
interface alu_operand_loader_if;
    logic [4:0] sw;
    logic       btn_load;
    logic       btn_clear;
    logic [4:0] A;
    logic [4:0] B;
    logic [2:0] Fxn;
    logic       valid;
    logic [1:0] state;

    modport master (
        output sw, btn_load, btn_clear,
        input  A, B, Fxn, valid, state
    );

    modport slave (
        input  sw, btn_load, btn_clear,
        output A, B, Fxn, valid, state
    );
endinterface

// File: rtl/alu_operand_loader.sv
// Loads ALU operands A, B and the function select from switches, one debounced load press per field.
// A debounced clear press returns the loader to the empty state.
module alu_operand_loader #(
    parameter int DEB_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_operand_loader_if.slave   bus
);

    typedef enum logic [1:0] {
        S_A   = 2'b00,
        S_B   = 2'b01,
        S_F   = 2'b10,
        S_RDY = 2'b11
    } state_t;

    localparam logic [15:0] CNT_MAX = 16'(DEB_CYCLES - 1);

    // Bit 0 is the load button, bit 1 is the clear button.
    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_deb;
    logic [1:0]       r_debPrev;
    logic [1:0]       r_pulse;
    logic [1:0][15:0] r_cnt;

    state_t     r_state;
    state_t     w_stateNext;
    logic [4:0] r_a;
    logic [4:0] r_b;
    logic [2:0] r_fxn;
    logic       r_valid;
    logic [4:0] w_aNext;
    logic [4:0] w_bNext;
    logic [2:0] w_fxnNext;
    logic       w_loadEv;
    logic       w_clearEv;

    // The debounced level changes only after DEB_CYCLES consecutive cycles in which the synchronized level
    // disagrees with it, so shorter bursts are absorbed. The pulse fires one cycle after a rising debounced level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_deb     <= '0;
            r_debPrev <= '0;
            r_pulse   <= '0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= {bus.btn_clear, bus.btn_load};
            r_sync2   <= r_sync1;
            r_debPrev <= r_deb;
            r_pulse   <= r_deb & ~r_debPrev;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_deb[i] <= ~r_deb[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign w_loadEv  = r_pulse[0];
    assign w_clearEv = r_pulse[1];

    always_comb begin
        w_stateNext = r_state;
        w_aNext     = r_a;
        w_bNext     = r_b;
        w_fxnNext   = r_fxn;
        if (w_clearEv) begin
            w_stateNext = S_A;
            w_aNext     = '0;
            w_bNext     = '0;
            w_fxnNext   = '0;
        end else if (w_loadEv) begin
            unique case (r_state)
                S_A: begin
                    w_aNext     = bus.sw;
                    w_stateNext = S_B;
                end
                S_B: begin
                    w_bNext     = bus.sw;
                    w_stateNext = S_F;
                end
                S_F: begin
                    w_fxnNext   = bus.sw[2:0];
                    w_stateNext = S_RDY;
                end
                S_RDY: begin
                    // A new operation starts here; B and Fxn stay until they are reloaded.
                    w_aNext     = bus.sw;
                    w_stateNext = S_B;
                end
                default: w_stateNext = S_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_A;
            r_a     <= '0;
            r_b     <= '0;
            r_fxn   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_a     <= w_aNext;
            r_b     <= w_bNext;
            r_fxn   <= w_fxnNext;
            r_valid <= (w_stateNext == S_RDY);
        end
    end

    assign bus.A     = r_a;
    assign bus.B     = r_b;
    assign bus.Fxn   = r_fxn;
    assign bus.valid = r_valid;
    assign bus.state = r_state;

endmodule
